// File: rtl/dekatron_step_ctrl.sv
// dekatron_step_ctrl
// Sequencer for a chain of dekatron counting tubes. It accepts one increment
// or decrement request at a time and drives two-phase guide pulses (G1 then
// G2) into the digits, starting at digit 0. Each guide phase is held for
// PULSE_CYCLES clocks. A carry or borrow ripples upward one digit at a time.
// A BCD shadow of the chain value is kept and exported on OUT.
//
// Ports:
//   CLOCK  in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   REQ    in   step request level, sampled only in IDLE
//   DIR    in   step direction (0 = increment, 1 = decrement), latched on accept
//   CLR    in   clear-to-zero request, sampled only in IDLE, wins over REQ
//   ACK    out  one-cycle pulse when an operation completes
//   BUSY   out  high in every state except IDLE
//   G1     out  guide-1 pulse, one bit per digit
//   G2     out  guide-2 pulse, one bit per digit
//   OUT    out  BCD chain value, digit 0 in bits [3:0]
//   ZERO   out  combinational, high when OUT is zero
//   OVF    out  pulses with ACK when the top digit wrapped
module dekatron_step_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                  CLOCK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  DIR,
  input  logic                  CLR,
  output logic                  ACK,
  output logic                  BUSY,
  output logic [DIGITS-1:0]     G1,
  output logic [DIGITS-1:0]     G2,
  output logic [4*DIGITS-1:0]   OUT,
  output logic                  ZERO,
  output logic                  OVF
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int OW = 4 * DIGITS;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH1  = 2'd1,
    ST_PH2  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One BCD digit step. Result is {wrap, new_digit}.
  function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic down);
    logic [4:0] res;
    if (!down) begin
      if (digit >= 4'd9) begin
        res = {1'b1, 4'd0};
      end else begin
        res = {1'b0, digit + 4'd1};
      end
    end else begin
      if (digit == 4'd0) begin
        res = {1'b1, 4'd9};
      end else begin
        res = {1'b0, digit - 4'd1};
      end
    end
    return res;
  endfunction

  state_t          state_r, state_nx_s;
  logic [PW-1:0]   phase_r, phase_nx_s;
  logic [KW-1:0]   k_r, k_nx_s;
  logic            dir_r, dir_nx_s;
  logic            ovf_flag_r, ovf_flag_nx_s;
  logic [OW-1:0]   out_r, out_nx_s;
  logic [4:0]      step_s;
  logic [KW+1:0]   digit_base_s;

  logic [DIGITS-1:0] g1_r, g2_r, g1_nx_s, g2_nx_s;
  logic              ack_r, ovf_r, busy_r;
  logic              ack_nx_s, ovf_nx_s, busy_nx_s;

  // Next-state, phase timing, digit index and BCD shadow update.
  always_comb begin
    state_nx_s    = state_r;
    phase_nx_s    = phase_r;
    k_nx_s        = k_r;
    dir_nx_s      = dir_r;
    ovf_flag_nx_s = ovf_flag_r;
    out_nx_s      = out_r;
    digit_base_s  = {k_r, 2'b00};
    step_s        = bcd_step(out_r[digit_base_s +: 4], dir_r);

    case (state_r)
      ST_IDLE: begin
        phase_nx_s    = {PW{1'b0}};
        ovf_flag_nx_s = 1'b0;
        if (CLR) begin
          out_nx_s   = {OW{1'b0}};
          state_nx_s = ST_DONE;
        end else if (REQ) begin
          dir_nx_s   = DIR;
          k_nx_s     = {KW{1'b0}};
          state_nx_s = ST_PH1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_PH1: begin
        if (phase_r == P_LAST) begin
          phase_nx_s = {PW{1'b0}};
          state_nx_s = ST_PH2;
        end else begin
          phase_nx_s = phase_r + PW'(1);
        end
      end

      ST_PH2: begin
        if (phase_r == P_LAST) begin
          phase_nx_s = {PW{1'b0}};
          // The digit settles on the edge that ends G2.
          out_nx_s[digit_base_s +: 4] = step_s[3:0];
          if (step_s[4]) begin
            if (k_r == K_LAST) begin
              ovf_flag_nx_s = 1'b1;
              state_nx_s    = ST_DONE;
            end else begin
              k_nx_s     = k_r + KW'(1);
              state_nx_s = ST_PH1;
            end
          end else begin
            state_nx_s = ST_DONE;
          end
        end else begin
          phase_nx_s = phase_r + PW'(1);
        end
      end

      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    g1_nx_s = {DIGITS{1'b0}};
    g2_nx_s = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (k_nx_s == KW'(i)) begin
        g1_nx_s[i] = (state_nx_s == ST_PH1);
        g2_nx_s[i] = (state_nx_s == ST_PH2);
      end else begin
        g1_nx_s[i] = 1'b0;
        g2_nx_s[i] = 1'b0;
      end
    end
    ack_nx_s  = (state_nx_s == ST_DONE);
    ovf_nx_s  = (state_nx_s == ST_DONE) && ovf_flag_nx_s;
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      phase_r    <= {PW{1'b0}};
      k_r        <= {KW{1'b0}};
      dir_r      <= 1'b0;
      ovf_flag_r <= 1'b0;
      out_r      <= {OW{1'b0}};
      g1_r       <= {DIGITS{1'b0}};
      g2_r       <= {DIGITS{1'b0}};
      ack_r      <= 1'b0;
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      phase_r    <= phase_nx_s;
      k_r        <= k_nx_s;
      dir_r      <= dir_nx_s;
      ovf_flag_r <= ovf_flag_nx_s;
      out_r      <= out_nx_s;
      g1_r       <= g1_nx_s;
      g2_r       <= g2_nx_s;
      ack_r      <= ack_nx_s;
      ovf_r      <= ovf_nx_s;
      busy_r     <= busy_nx_s;
    end
  end

  assign ACK  = ack_r;
  assign BUSY = busy_r;
  assign G1   = g1_r;
  assign G2   = g2_r;
  assign OUT  = out_r;
  assign OVF  = ovf_r;
  assign ZERO = (out_r == {OW{1'b0}});

endmodule

// File: tb/tb_dekatron_step_ctrl.sv
module tb_dekatron_step_ctrl;

  localparam int D = 4;
  localparam int P = 2;

  logic         CLOCK = 1'b0;
  logic         RST   = 1'b1;
  logic         REQ   = 1'b0;
  logic         DIR   = 1'b0;
  logic         CLR   = 1'b0;
  logic         ACK, BUSY, ZERO, OVF;
  logic [D-1:0] G1, G2;
  logic [4*D-1:0] OUT;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;

  typedef struct {
    logic [15:0] out;
    logic        ovf;
    int          ack_cycle;
  } exp_t;

  exp_t sb_q[$];

  dekatron_step_ctrl #(.DIGITS(D), .PULSE_CYCLES(P)) dut (
    .CLOCK(CLOCK), .RST(RST), .REQ(REQ), .DIR(DIR), .CLR(CLR),
    .ACK(ACK), .BUSY(BUSY), .G1(G1), .G2(G2), .OUT(OUT),
    .ZERO(ZERO), .OVF(OVF)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One operation: model update, scoreboard push, drive, per-cycle guide watch, pop at ACK.
  task automatic run_op(input logic do_clr, input logic do_req, input logic dir,
                        input int clr_at, input int req_at, input string name);
    int n, t, eack, c, gerr, bad_c;
    logic eov, got;
    logic [3:0] one, eg1, eg2, bg1, bg2, be1, be2;
    exp_t e;
    one = 4'b0001;
    if (do_clr) begin
      n = 0; model = 0; eov = 1'b0;
    end else begin
      n = 1; t = model;
      if (!dir) begin
        while (n < D && t % 10 == 9) begin n++; t = t / 10; end
        eov = (model == 9999);
        model = (model + 1) % 10000;
      end else begin
        while (n < D && t % 10 == 0) begin n++; t = t / 10; end
        eov = (model == 0);
        model = (model + 9999) % 10000;
      end
    end
    eack = 2 * P * n + 1;
    sb_q.push_back('{to_bcd(model), eov, eack});

    @(negedge CLOCK);
    REQ = do_req; CLR = do_clr; DIR = dir;
    @(negedge CLOCK);
    DIR = ~dir;
    got = 1'b0; gerr = 0; bad_c = 0;
    bg1 = 4'b0; bg2 = 4'b0; be1 = 4'b0; be2 = 4'b0;
    for (c = 1; c <= 40 && !got; c++) begin
      if (c > 1) @(negedge CLOCK);
      REQ = (c == req_at);
      CLR = (c == clr_at);
      eg1 = 4'b0; eg2 = 4'b0;
      if (c <= 2 * P * n) begin
        if (((c - 1) % (2 * P)) < P) eg1 = one << ((c - 1) / (2 * P));
        else                          eg2 = one << ((c - 1) / (2 * P));
      end
      if (G1 !== eg1 || G2 !== eg2 || BUSY !== 1'b1 || (!ACK && OVF !== 1'b0)) begin
        if (gerr == 0) begin bad_c = c; bg1 = G1; bg2 = G2; be1 = eg1; be2 = eg2; end
        gerr++;
      end
      if (ACK === 1'b1) begin
        got = 1'b1;
        e = sb_q.pop_front();
        n_checks++;
        if (c !== e.ack_cycle) begin
          n_fail++;
          $display("FAIL %s ack_cycle: got %0d expected %0d", name, c, e.ack_cycle);
        end
        n_checks++;
        if (OUT !== e.out) begin
          n_fail++;
          $display("FAIL %s out: got %h expected %h", name, OUT, e.out);
        end
        n_checks++;
        if (OVF !== e.ovf) begin
          n_fail++;
          $display("FAIL %s ovf: got %b expected %b", name, OVF, e.ovf);
        end
        n_checks++;
        if (ZERO !== (e.out == 16'h0000)) begin
          n_fail++;
          $display("FAIL %s zero: got %b expected %b", name, ZERO, (e.out == 16'h0000));
        end
      end
    end
    REQ = 1'b0; CLR = 1'b0;
    if (!got) begin
      e = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s ack_timeout: got no ACK expected ACK in cycle %0d", name, e.ack_cycle);
    end
    n_checks++;
    if (gerr != 0) begin
      n_fail++;
      $display("FAIL %s guides: cycle %0d got G1=%b G2=%b expected G1=%b G2=%b (BUSY=1, OVF=0)",
               name, bad_c, bg1, bg2, be1, be2);
    end
    @(negedge CLOCK);
    n_checks++;
    if (ACK !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_ack: got ACK=%b BUSY=%b OVF=%b expected 0 0 0", name, ACK, BUSY, OVF);
    end
  endtask

  task automatic preload(input int v);
    run_op(1'b1, 1'b0, 1'b0, 0, 0, "preload_clr");
    for (int i = 0; i < v; i++) run_op(1'b0, 1'b1, 1'b0, 0, 0, "preload_inc");
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    RST = 1'b0;
    model = 0;
    #1;
    n_checks++;
    if (OUT !== 16'h0000 || ZERO !== 1'b1 || G1 !== 4'b0 || G2 !== 4'b0 ||
        BUSY !== 1'b0 || ACK !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got OUT=%h ZERO=%b G1=%b G2=%b BUSY=%b ACK=%b OVF=%b expected 0000 1 0 0 0 0 0",
               OUT, ZERO, G1, G2, BUSY, ACK, OVF);
    end
    @(negedge CLOCK);
    REQ = 1'b1; DIR = 1'b0;
    @(negedge CLOCK);
    REQ = 1'b0;
    @(negedge CLOCK);
    n_checks++;
    if (G1 !== 4'b0001 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_async: got G1=%b BUSY=%b expected 0001 1", G1, BUSY);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (OUT !== 16'h0000 || ZERO !== 1'b1 || G1 !== 4'b0 || G2 !== 4'b0 ||
        BUSY !== 1'b0 || ACK !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got OUT=%h ZERO=%b G1=%b G2=%b BUSY=%b ACK=%b OVF=%b expected 0000 1 0 0 0 0 0",
               OUT, ZERO, G1, G2, BUSY, ACK, OVF);
    end
    @(negedge CLOCK);
    RST = 1'b0;
    model = 0;
  endtask

  task automatic test_single_inc();
    run_op(1'b0, 1'b1, 1'b0, 0, 0, "inc_0000");
  endtask

  task automatic test_ripple();
    preload(99);
    run_op(1'b0, 1'b1, 1'b0, 0, 0, "inc_0099");
  endtask

  task automatic test_wrap();
    run_op(1'b1, 1'b0, 1'b0, 0, 0, "clr_before_wrap");
    run_op(1'b0, 1'b1, 1'b1, 0, 0, "dec_0000");
    run_op(1'b0, 1'b1, 1'b0, 0, 0, "inc_9999");
  endtask

  task automatic test_clr_priority();
    preload(42);
    n_checks++;
    if (OUT !== 16'h0042) begin
      n_fail++;
      $display("FAIL preload_42: got %h expected 0042", OUT);
    end
    run_op(1'b1, 1'b1, 1'b0, 0, 0, "clr_and_req");
    run_op(1'b0, 1'b1, 1'b0, 1, 0, "clr_in_ph1");
    run_op(1'b0, 1'b1, 1'b0, 0, 3, "req_in_ph2");
    @(negedge CLOCK);
    n_checks++;
    if (BUSY !== 1'b0 || G1 !== 4'b0 || OUT !== 16'h0002) begin
      n_fail++;
      $display("FAIL no_queued_req: got BUSY=%b G1=%b OUT=%h expected 0 0000 0002", BUSY, G1, OUT);
    end
  endtask

  task automatic test_reset_mid_ripple();
    preload(99);
    @(negedge CLOCK);
    REQ = 1'b1; DIR = 1'b0;
    @(negedge CLOCK);
    REQ = 1'b0;
    repeat (6) @(negedge CLOCK);
    n_checks++;
    if (G2 !== 4'b0010) begin
      n_fail++;
      $display("FAIL ripple_g2_1: got G2=%b expected 0010", G2);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (G2 !== 4'b0 || G1 !== 4'b0 || OUT !== 16'h0000 || BUSY !== 1'b0 || ZERO !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ripple: got G1=%b G2=%b OUT=%h BUSY=%b ZERO=%b expected 0000 0000 0000 0 1",
               G1, G2, OUT, BUSY, ZERO);
    end
    repeat (2) @(negedge CLOCK);
    RST = 1'b0;
    model = 0;
    run_op(1'b0, 1'b1, 1'b0, 0, 0, "inc_after_reset");
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_ripple();
    test_wrap();
    test_clr_priority();
    test_reset_mid_ripple();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dekatron_step_ctrl.md
Name: dekatron_step_ctrl

Overview:
Sequencer for the dekatron counter chain behind the 16-bit OUT display of dekatronpc. It accepts one increment or decrement request at a time and drives two-phase guide pulses (G1 then G2) to each digit in turn, rippling carry or borrow upward. It keeps a BCD shadow of the chain's value, and the top level exports that value as OUT. The instruction logic is the only requester.

Parameters:
DIGITS, 4, number of decimal digits in the chain; OUT width is 4*DIGITS.
PULSE_CYCLES, 2, CLOCK cycles each guide phase is held; must be at least 1.

Ports:
CLOCK  in  1  system clock; all state changes on its rising edge.
RST  in  1  asynchronous, active-high reset.
REQ  in  1  step request, level; sampled only in IDLE.
DIR  in  1  step direction: 0 = increment, 1 = decrement; latched when REQ is accepted.
CLR  in  1  clear-to-zero request; sampled only in IDLE.
ACK  out  1  one-cycle pulse when an operation completes.
BUSY  out  1  high in every state except IDLE.
G1  out  DIGITS  guide-1 pulse, one bit per digit.
G2  out  DIGITS  guide-2 pulse, one bit per digit.
OUT  out  4*DIGITS  BCD value; digit 0 in bits [3:0].
ZERO  out  1  combinational; high when OUT == 0.
OVF  out  1  pulses together with ACK when the top digit wraps.

Behaviour:
- States: IDLE, PH1, PH2, DONE. Registers:
  - phase counter, 0..PULSE_CYCLES-1;
  - digit index k;
  - latched DIR.
- Reset, asynchronous, takes effect immediately, also mid-operation:
  - state IDLE, k = 0, counter = 0;
  - OUT = 0, G1 = 0, G2 = 0, ACK = 0, OVF = 0, BUSY = 0;
  - ZERO = 1.
- IDLE:
  - CLR=1 has priority over REQ. It sets OUT to 0, moves to DONE (ACK next cycle) and generates no guide pulses.
  - Else REQ=1 latches DIR, sets k = 0 and moves to PH1.
  - Else stay in IDLE.
- PH1: G1[k]=1, all other guide bits 0. After PULSE_CYCLES cycles, move to PH2.
- PH2: G2[k]=1. On the edge that leaves PH2 after PULSE_CYCLES cycles, digit k updates:
  - increment: 9 -> 0 is a wrap, otherwise +1;
  - decrement: 0 -> 9 is a wrap, otherwise -1.
- Next state on that same edge:
  - wrap and k < DIGITS-1: k = k+1, go to PH1 (ripple);
  - wrap and k = DIGITS-1: set the OVF flag, go to DONE;
  - no wrap: go to DONE.
- DONE: ACK=1 for exactly one cycle; OVF=1 in this same cycle if flagged; then IDLE. OVF clears on leaving DONE.
- Guide outputs are registered and decoded from state.
  - G1 and G2 are never high simultaneously.
  - At most one bit across G1|G2 is high at any time.
  - All guide bits are 0 in IDLE and DONE.
- Latency: acceptance edge = cycle 0. An operation touching n digits drives ACK during cycle 2*PULSE_CYCLES*n + 1. With PULSE_CYCLES=2: no ripple gives ACK in cycle 5; each extra digit adds 4 cycles.
- OUT only changes on PH2-exit edges, on a CLR, or on reset. Intermediate ripple values are visible, e.g. 0099 -> 0090 -> 0000 -> 0100.
- REQ and CLR while BUSY are ignored and not queued. The requester drops REQ on seeing ACK. REQ still high in the IDLE cycle after DONE starts a new step.
- DIR changes while BUSY have no effect.

Test Plan:
1. Assert RST for 3 cycles, release -> OUT=0x0000, ZERO=1, G1=G2=0, BUSY=0, ACK=0. Assert RST again -> all outputs return to these values asynchronously.
2. From 0000, REQ=1, DIR=0 for 1 cycle -> G1=0001 in cycles 1-2, G2=0001 in cycles 3-4, ACK=1 in cycle 5, OUT=0x0001, ZERO=0, OVF=0.
3. Preload 0x0099 (99 increments), then increment:
   - G1/G2 pulses on bit 0, then bit 1, then bit 2 in order;
   - ACK in cycle 13;
   - OUT=0x0100.
4. From 0000, decrement:
   - four digit steps, ACK in cycle 17, OVF=1 in the same cycle;
   - OUT=0x9999.
   Then increment -> OUT=0x0000, OVF=1, ACK in cycle 17, ZERO=1.
5. Preload 0x0042.
   - Pulse CLR and REQ together in IDLE -> CLR wins: OUT=0x0000, ACK next cycle, no guide pulses.
   - Start an increment, then pulse CLR during PH1 -> CLR ignored, OUT=0x0001 at ACK.
   - Pulse REQ during PH2 -> no second operation starts.
6. Preload 0x0099, start an increment, assert RST during G2[1] -> G2 drops to 0 before the next edge; OUT=0x0000; state IDLE. After release, an increment completes normally with OUT=0x0001.
